dmem_arbiter: RTL and testbench

//   Sequences every access to the single-port data memory and shares it between two requesters.

---
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester sequencer for the single-port data memory: the pipeline MEM stage and the
// debug/loader port share it, one registered multi-cycle transaction at a time.
module dmem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_req,
   input  logic          pipe_we,
   input  logic [AW-1:0] pipe_addr,
   input  logic [DW-1:0] pipe_wdata,
   output logic          pipe_ack,
   output logic [DW-1:0] pipe_rdata,
   output logic          pipe_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          owner_q;      // 0 = pipeline, 1 = debug
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [LW-1:0] lat_cnt;
   logic [SW-1:0] starve_cnt;
   logic          any_req;
   logic          dbg_win;

   assign any_req = pipe_req | dbg_req;
   // Debug only beats a live pipeline request once the pipeline has had its run of grants.
   assign dbg_win = dbg_req & (~pipe_req | (starve_cnt == SW'(STARVE_MAX)));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = (we_q || (MEM_LAT <= 1)) ? S_DONE : S_WAIT;
         S_WAIT:  if (lat_cnt == LW'(1)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Transaction latch, latency counter and starvation counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  owner_q <= dbg_win;
                  we_q    <= dbg_win ? dbg_we    : pipe_we;
                  addr_q  <= dbg_win ? dbg_addr  : pipe_addr;
                  wdata_q <= dbg_win ? dbg_wdata : pipe_wdata;
               end
               if (!dbg_req || dbg_win)
                  starve_cnt <= '0;
               else if (starve_cnt != SW'(STARVE_MAX))
                  starve_cnt <= starve_cnt + SW'(1);
            end
            S_ISSUE: lat_cnt <= LW'(MEM_LAT - 1);
            S_WAIT:  lat_cnt <= lat_cnt - LW'(1);
            default: ;
         endcase
      end
   end

   // Output decode from the registered state and latched transaction
   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      pipe_ack   = 1'b0;
      dbg_ack    = 1'b0;
      pipe_rdata = '0;
      dbg_rdata  = '0;
      if (state == S_ISSUE) begin
         mem_en = 1'b1;
         mem_we = we_q;
      end
      if (state == S_DONE) begin
         pipe_ack = ~owner_q;
         dbg_ack  = owner_q;
         if (!we_q) begin
            if (owner_q) dbg_rdata  = mem_rdata;
            else         pipe_rdata = mem_rdata;
         end
      end
      pipe_stall = rst & pipe_req & ~pipe_ack;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers queue expected acks, monitors pop and compare.
module tb_dmem_arbiter;

   typedef struct {
      bit          dbg;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   en_cnt_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: MEM_LAT=2, STARVE_MAX=4
   logic        pipe_req_a = 0, pipe_we_a = 0, dbg_req_a = 0, dbg_we_a = 0;
   logic [31:0] pipe_addr_a = 0, pipe_wdata_a = 0, dbg_addr_a = 0, dbg_wdata_a = 0;
   logic        pipe_ack_a, pipe_stall_a, dbg_ack_a, mem_en_a, mem_we_a;
   logic [31:0] pipe_rdata_a, dbg_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
   logic [31:0] mem_a [16];
   logic [31:0] rd_a0 = 0, rd_a1 = 0;

   // DUT B: MEM_LAT=1
   logic        pipe_req_b = 0, pipe_we_b = 0, dbg_req_b = 0, dbg_we_b = 0;
   logic [31:0] pipe_addr_b = 0, pipe_wdata_b = 0, dbg_addr_b = 0, dbg_wdata_b = 0;
   logic        pipe_ack_b, pipe_stall_b, dbg_ack_b, mem_en_b, mem_we_b;
   logic [31:0] pipe_rdata_b, dbg_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
   logic [31:0] mem_b [16];
   logic [31:0] rd_b0 = 0;

   dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut_a (
      .clk(clk), .rst(rst),
      .pipe_req(pipe_req_a), .pipe_we(pipe_we_a), .pipe_addr(pipe_addr_a), .pipe_wdata(pipe_wdata_a),
      .pipe_ack(pipe_ack_a), .pipe_rdata(pipe_rdata_a), .pipe_stall(pipe_stall_a),
      .dbg_req(dbg_req_a), .dbg_we(dbg_we_a), .dbg_addr(dbg_addr_a), .dbg_wdata(dbg_wdata_a),
      .dbg_ack(dbg_ack_a), .dbg_rdata(dbg_rdata_a),
      .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .mem_rdata(mem_rdata_a)
   );

   dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_b (
      .clk(clk), .rst(rst),
      .pipe_req(pipe_req_b), .pipe_we(pipe_we_b), .pipe_addr(pipe_addr_b), .pipe_wdata(pipe_wdata_b),
      .pipe_ack(pipe_ack_b), .pipe_rdata(pipe_rdata_b), .pipe_stall(pipe_stall_b),
      .dbg_req(dbg_req_b), .dbg_we(dbg_we_b), .dbg_addr(dbg_addr_b), .dbg_wdata(dbg_wdata_b),
      .dbg_ack(dbg_ack_b), .dbg_rdata(dbg_rdata_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b)
   );

   // Memory models; non-read cycles return garbage so unqualified rdata shows up
   always @(posedge clk) begin
      if (mem_en_a && mem_we_a) mem_a[mem_addr_a[3:0]] <= mem_wdata_a;
      rd_a0 <= (mem_en_a && !mem_we_a) ? mem_a[mem_addr_a[3:0]] : 32'hDEAD_BEEF;
      rd_a1 <= rd_a0;
      if (mem_en_b && mem_we_b) mem_b[mem_addr_b[3:0]] <= mem_wdata_b;
      rd_b0 <= (mem_en_b && !mem_we_b) ? mem_b[mem_addr_b[3:0]] : 32'hDEAD_BEEF;
      if (mem_en_b) en_cnt_b <= en_cnt_b + 1;
   end
   assign mem_rdata_a = rd_a1;
   assign mem_rdata_b = rd_b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic cmp_ack(input string nm, input bit have, input exp_t e, input logic pa,
                          input logic da, input logic [31:0] pr, input logic [31:0] dr);
      logic [31:0] own_rd;
      logic [31:0] oth_rd;
      own_rd = e.dbg ? dr : pr;
      oth_rd = e.dbg ? pr : dr;
      n_tests++;
      if (!have) begin
         n_fail++;
         $display("FAIL %s unexpected ack: pipe_ack=%b dbg_ack=%b at cycle %0d, none required", nm, pa, da, cyc);
      end else if ((pa && da) || (da !== e.dbg) || (own_rd !== e.rdata) || (oth_rd !== 32'h0) ||
                   (cyc != e.cyc)) begin
         n_fail++;
         $display("FAIL %s ack: got pipe_ack=%b dbg_ack=%b rdata=%h other_rdata=%h cycle=%0d, expected dbg=%b rdata=%h cycle=%0d",
                  nm, pa, da, own_rd, oth_rd, cyc, e.dbg, e.rdata, e.cyc);
      end
   endtask

   // Monitors
   always @(negedge clk) begin : mon_a
      exp_t e;
      bit   have;
      if (pipe_ack_a || dbg_ack_a) begin
         have = (q_a.size() > 0);
         e = have ? q_a.pop_front() : '{dbg: 1'b0, rdata: 32'h0, cyc: 0};
         cmp_ack("A", have, e, pipe_ack_a, dbg_ack_a, pipe_rdata_a, dbg_rdata_a);
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      bit   have;
      if (pipe_ack_b || dbg_ack_b) begin
         have = (q_b.size() > 0);
         e = have ? q_b.pop_front() : '{dbg: 1'b0, rdata: 32'h0, cyc: 0};
         cmp_ack("B", have, e, pipe_ack_b, dbg_ack_b, pipe_rdata_b, dbg_rdata_b);
      end
   end

   // Drivers: called at a negedge with the DUT idle, return at the negedge of the next idle cycle
   task automatic pipe_a(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
      int lat;
      lat = we ? 2 : 3;
      pipe_req_a = 1; pipe_we_a = we; pipe_addr_a = addr; pipe_wdata_a = wd;
      q_a.push_back('{dbg: 1'b0, rdata: (we ? 32'h0 : rd), cyc: cyc + lat});
      repeat (lat) @(negedge clk);
      pipe_req_a = 0;
      @(negedge clk);
   endtask

   task automatic dbg_a(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
      int lat;
      lat = we ? 2 : 3;
      dbg_req_a = 1; dbg_we_a = we; dbg_addr_a = addr; dbg_wdata_a = wd;
      q_a.push_back('{dbg: 1'b1, rdata: (we ? 32'h0 : rd), cyc: cyc + lat});
      repeat (lat) @(negedge clk);
      dbg_req_a = 0;
      @(negedge clk);
   endtask

   task automatic pipe_b(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
      pipe_req_b = 1; pipe_we_b = we; pipe_addr_b = addr; pipe_wdata_b = wd;
      q_b.push_back('{dbg: 1'b0, rdata: (we ? 32'h0 : rd), cyc: cyc + 2});
      repeat (2) @(negedge clk);
      pipe_req_b = 0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin : stim
      int c0;
      int en0;
      repeat (2) @(negedge clk);
      // Reset state, including stall held low while reset is active
      pipe_req_a = 1;
      #1;
      chk("rst pipe_stall", 32'(pipe_stall_a), 0);
      chk("rst mem_en", 32'(mem_en_a), 0);
      chk("rst pipe_ack", 32'(pipe_ack_a), 0);
      chk("rst dbg_ack", 32'(dbg_ack_a), 0);
      chk("rst mem_addr", mem_addr_a, 0);
      pipe_req_a = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);

      // Preload through the debug port
      dbg_a(1, 3, 32'hA5A5_A5A5, 0);

      // Pipe read addr 3
      c0 = cyc;
      pipe_req_a = 1; pipe_we_a = 0; pipe_addr_a = 3;
      q_a.push_back('{dbg: 1'b0, rdata: 32'hA5A5_A5A5, cyc: c0 + 3});
      #1 chk("t1 stall c0", 32'(pipe_stall_a), 1);
      @(negedge clk);
      chk("t1 mem_en c1", 32'(mem_en_a), 1);
      chk("t1 mem_we c1", 32'(mem_we_a), 0);
      chk("t1 mem_addr c1", mem_addr_a, 3);
      chk("t1 stall c1", 32'(pipe_stall_a), 1);
      @(negedge clk);
      chk("t1 mem_en c2", 32'(mem_en_a), 0);
      chk("t1 stall c2", 32'(pipe_stall_a), 1);
      @(negedge clk);
      chk("t1 stall c3", 32'(pipe_stall_a), 0);
      pipe_req_a = 0;
      @(negedge clk);

      // Pipe write addr 2 then read back
      c0 = cyc;
      pipe_req_a = 1; pipe_we_a = 1; pipe_addr_a = 2; pipe_wdata_a = 32'h1234;
      q_a.push_back('{dbg: 1'b0, rdata: 32'h0, cyc: c0 + 2});
      @(negedge clk);
      chk("t2 mem_en", 32'(mem_en_a), 1);
      chk("t2 mem_we", 32'(mem_we_a), 1);
      chk("t2 mem_wdata", mem_wdata_a, 32'h1234);
      @(negedge clk);
      pipe_req_a = 0;
      @(negedge clk);
      pipe_a(0, 2, 0, 32'h1234);

      // Both requesters held: P,P,P,P,D,P,P,P,P,D
      c0 = cyc;
      pipe_req_a = 1; pipe_we_a = 1; pipe_addr_a = 4; pipe_wdata_a = 32'h100;
      dbg_req_a = 1; dbg_we_a = 1; dbg_addr_a = 5; dbg_wdata_a = 32'h200;
      for (int i = 0; i < 10; i++)
         q_a.push_back('{dbg: ((i % 5) == 4), rdata: 32'h0, cyc: c0 + 3 * i + 2});
      repeat (29) @(negedge clk);
      pipe_req_a = 0; dbg_req_a = 0;
      @(negedge clk);
      pipe_a(0, 4, 0, 32'h100);
      dbg_a(0, 5, 0, 32'h200);

      // Pipe request arrives while a debug read waits
      c0 = cyc;
      dbg_req_a = 1; dbg_we_a = 0; dbg_addr_a = 3;
      q_a.push_back('{dbg: 1'b1, rdata: 32'hA5A5_A5A5, cyc: c0 + 3});
      repeat (2) @(negedge clk);
      pipe_req_a = 1; pipe_we_a = 0; pipe_addr_a = 2;
      q_a.push_back('{dbg: 1'b0, rdata: 32'h1234, cyc: c0 + 7});
      #1 chk("t4 stall c2", 32'(pipe_stall_a), 1);
      @(negedge clk);
      chk("t4 stall c3", 32'(pipe_stall_a), 1);
      dbg_req_a = 0;
      @(negedge clk);
      chk("t4 stall c4", 32'(pipe_stall_a), 1);
      chk("t4 mem_en c4", 32'(mem_en_a), 0);
      @(negedge clk);
      chk("t4 mem_en c5", 32'(mem_en_a), 1);
      chk("t4 mem_addr c5", mem_addr_a, 2);
      @(negedge clk);
      chk("t4 stall c6", 32'(pipe_stall_a), 1);
      @(negedge clk);
      chk("t4 stall c7", 32'(pipe_stall_a), 0);
      pipe_req_a = 0;
      @(negedge clk);

      // Reset during WAIT of a pipe read abandons it
      pipe_req_a = 1; pipe_we_a = 0; pipe_addr_a = 3;
      repeat (2) @(negedge clk);
      rst = 0;
      #1;
      chk("t5 mem_en", 32'(mem_en_a), 0);
      chk("t5 mem_addr", mem_addr_a, 0);
      chk("t5 pipe_stall", 32'(pipe_stall_a), 0);
      chk("t5 pipe_ack", 32'(pipe_ack_a), 0);
      chk("t5 pipe_rdata", pipe_rdata_a, 0);
      pipe_req_a = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      pipe_a(0, 3, 0, 32'hA5A5_A5A5);

      // MEM_LAT=1: write, then read with request dropped in ISSUE
      pipe_b(1, 7, 32'h5A5A_0007, 0);
      c0 = cyc;
      en0 = en_cnt_b;
      pipe_req_b = 1; pipe_we_b = 0; pipe_addr_b = 7;
      q_b.push_back('{dbg: 1'b0, rdata: 32'h5A5A_0007, cyc: c0 + 2});
      @(negedge clk);
      chk("t6 mem_en", 32'(mem_en_b), 1);
      pipe_req_b = 0;
      repeat (4) @(negedge clk);
      chk("t6 single mem_en", 32'(en_cnt_b - en0), 1);

      repeat (3) @(negedge clk);
      chk("queue A drained", 32'(q_a.size()), 0);
      chk("queue B drained", 32'(q_b.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
